// File: rtl/freq_calc.sv
// rtl/freq_calc.sv - frequency, duty and period computation from gate counters via a shared serial divider
module freq_calc #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned NS_PER_CLK = 10,
    parameter int unsigned DUTY_SCALE = 1000
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic [31:0] cnt_clk,
    input  logic [31:0] cnt_squ,
    input  logic [31:0] cnt_pulse,
    input  logic        upd,
    output logic [31:0] freq_hz,
    output logic [9:0]  duty_pm,
    output logic [31:0] period_ns,
    output logic        done,
    output logic        busy,
    output logic        err_div0,
    output logic        sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV_F,
        S_DIV_D,
        S_DIV_P,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] snap_clk;
    logic [31:0] snap_squ;
    logic [31:0] snap_pulse;
    logic        pending;
    logic        trigger;

    logic [5:0]  iter;
    logic        last_iter;
    logic [63:0] div_quo;
    logic [31:0] div_rem;
    logic [31:0] div_dsr;
    logic        div_zero;

    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_nxt;
    logic [63:0] quo_nxt;
    logic        q_sat;
    logic [31:0] q32;
    logic        duty_over;
    logic [9:0]  duty_val;

    logic [63:0] prod_f;
    logic [63:0] prod_d;
    logic [63:0] prod_p;
    logic [63:0] ld_dvd;
    logic [31:0] ld_dsr;

    logic [31:0] res_freq;
    logic [9:0]  res_duty;
    logic [31:0] res_per;
    logic        res_div0;
    logic        res_sat;

    assign trigger   = upd || (cnt_clk != snap_clk) || (cnt_squ != snap_squ)
                       || (cnt_pulse != snap_pulse);
    assign last_iter = (iter == 6'd63);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (trigger) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_DIV_F;
            S_DIV_F: if (last_iter) state_nxt = S_DIV_D;
            S_DIV_D: if (last_iter) state_nxt = S_DIV_P;
            S_DIV_P: if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = (pending || trigger) ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshots are taken on the edge that enters LOAD, so the change compare
    // already matches during LOAD and only genuinely new activity marks pending.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            snap_clk   <= '0;
            snap_squ   <= '0;
            snap_pulse <= '0;
            pending    <= 1'b0;
        end else if (state_nxt == S_LOAD) begin
            snap_clk   <= cnt_clk;
            snap_squ   <= cnt_squ;
            snap_pulse <= cnt_pulse;
            pending    <= 1'b0;
        end else if (state != S_IDLE && trigger) begin
            pending    <= 1'b1;
        end
    end

    assign prod_f = 64'(snap_squ) * 64'(CLK_HZ);
    assign prod_d = 64'(snap_pulse) * 64'(DUTY_SCALE);
    assign prod_p = 64'(snap_clk) * 64'(NS_PER_CLK);

    always_comb begin
        ld_dvd = '0;
        ld_dsr = '0;
        case (state)
            S_LOAD: begin
                ld_dvd = prod_f;
                ld_dsr = snap_clk;
            end
            S_DIV_F: begin
                ld_dvd = prod_d;
                ld_dsr = snap_clk;
            end
            S_DIV_D: begin
                ld_dvd = prod_p;
                ld_dsr = snap_squ;
            end
            default: begin
                ld_dvd = '0;
                ld_dsr = '0;
            end
        endcase
    end

    // Restoring step; the 32-bit wrapping subtract is exact whenever fits is set.
    always_comb begin
        rem_sh    = {div_rem, div_quo[63]};
        fits      = (rem_sh >= {1'b0, div_dsr});
        rem_nxt   = fits ? (rem_sh[31:0] - div_dsr) : rem_sh[31:0];
        quo_nxt   = {div_quo[62:0], fits};
        q_sat     = !div_zero && (quo_nxt[63:32] != 32'd0);
        q32       = div_zero ? 32'd0 : (q_sat ? 32'hFFFF_FFFF : quo_nxt[31:0]);
        duty_over = (q32 > 32'(DUTY_SCALE));
        duty_val  = duty_over ? 10'(DUTY_SCALE) : q32[9:0];
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            iter     <= '0;
            div_quo  <= '0;
            div_rem  <= '0;
            div_dsr  <= '0;
            div_zero <= 1'b0;
            res_freq <= '0;
            res_duty <= '0;
            res_per  <= '0;
            res_div0 <= 1'b0;
            res_sat  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    iter     <= '0;
                    div_quo  <= ld_dvd;
                    div_rem  <= '0;
                    div_dsr  <= ld_dsr;
                    div_zero <= (ld_dsr == 32'd0);
                    res_div0 <= 1'b0;
                    res_sat  <= 1'b0;
                end
                S_DIV_F, S_DIV_D, S_DIV_P: begin
                    iter <= iter + 6'd1;
                    if (last_iter) begin
                        case (state)
                            S_DIV_F: res_freq <= q32;
                            S_DIV_D: res_duty <= duty_val;
                            default: res_per  <= q32;
                        endcase
                        res_div0 <= res_div0 || div_zero;
                        res_sat  <= res_sat || q_sat || ((state == S_DIV_D) && duty_over);
                        div_quo  <= ld_dvd;
                        div_rem  <= '0;
                        div_dsr  <= ld_dsr;
                        div_zero <= (ld_dsr == 32'd0);
                    end else if (!div_zero) begin
                        div_quo <= quo_nxt;
                        div_rem <= rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            freq_hz   <= '0;
            duty_pm   <= '0;
            period_ns <= '0;
            err_div0  <= 1'b0;
            sat       <= 1'b0;
            done      <= 1'b0;
        end else if (state == S_DONE) begin
            freq_hz   <= res_freq;
            duty_pm   <= res_duty;
            period_ns <= res_per;
            err_div0  <= res_div0;
            sat       <= res_sat;
            done      <= 1'b1;
        end else begin
            done      <= 1'b0;
        end
    end

endmodule

// File: doc/freq_calc.md
FREQ_CALC -- requirements
Module: freq_calc

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter NS_PER_CLK, default 10, system clock period in ns.
REQ-003 Parameter DUTY_SCALE, default 1000, full-scale duty value (permille).
REQ-004 clk_100M  input  1  system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cnt_clk  input  32  system-clock cycles counted in the last gate (from the measurement stage).
REQ-007 cnt_squ  input  32  input-signal periods counted in the last gate.
REQ-008 cnt_pulse  input  32  system-clock cycles with input high in the last gate.
REQ-009 upd  input  1  one-cycle recompute request; may be tied to 0.
REQ-010 freq_hz  output  32  measured frequency, Hz.
REQ-011 duty_pm  output  10  duty cycle, 0..DUTY_SCALE.
REQ-012 period_ns  output  32  average input period, ns.
REQ-013 done  output  1  one-cycle pulse when the result outputs update.
REQ-014 busy  output  1  computation in progress.
REQ-015 err_div0  output  1  last result had a zero divisor.
REQ-016 sat  output  1  last result had a saturated or clamped field.

Function
REQ-017 Trigger: upd==1, or any of cnt_clk/cnt_squ/cnt_pulse differs from the snapshot registers (reset 0).
REQ-018 FSM states: IDLE, LOAD, DIV_F, DIV_D, DIV_P, DONE; IDLE->LOAD on trigger; LOAD->DIV_F; each DIV_* runs exactly 64 iterations then advances; DIV_P->DONE; DONE->IDLE, or DONE->LOAD if a trigger is pending.
REQ-019 LOAD: copy all three inputs into the snapshot registers; later computation uses snapshots only.
REQ-020 Divider: one shared restoring divider, 64-bit dividend, 32-bit divisor, one quotient bit per cycle.
REQ-021 DIV_F: freq = cnt_squ*CLK_HZ / cnt_clk (64-bit product, unsigned, truncated).
REQ-022 DIV_D: duty = cnt_pulse*DUTY_SCALE / cnt_clk, clamped to DUTY_SCALE; a clamp sets sat.
REQ-023 DIV_P: period = cnt_clk*NS_PER_CLK / cnt_squ.
REQ-024 Any quotient >= 2^32 gives 0xFFFFFFFF and sets sat.
REQ-025 Zero divisor: skip that division's iterations (state still lasts 64 cycles), result 0, set err_div0.
REQ-026 Latency: trigger sampled at edge N -> LOAD at N; freq_hz/duty_pm/period_ns/err_div0/sat all update together at edge N+194; done is high only in the cycle after N+194.
REQ-027 busy is high from edge N until edge N+194, and low while in IDLE.
REQ-028 Result outputs hold between done pulses; they never show partial results.
REQ-029 A trigger while busy sets a one-deep pending flag; multiple triggers while busy collapse into one recompute using the input values at the next LOAD.
REQ-030 A trigger in the same cycle as DONE counts as pending.

Reset
REQ-031 On rst_n low, asynchronously: FSM to IDLE; snapshots, pending flag, divider registers and all outputs to 0.
REQ-032 Reset during a computation aborts it; no done pulse for that computation.
REQ-033 After rst_n deasserts, nonzero inputs re-trigger on the first clock through the change compare.

Verification
REQ-034 cnt_clk=100_000_000, cnt_squ=1000, cnt_pulse=25_000_000 -> freq_hz=1000, duty_pm=250, period_ns=1_000_000, err_div0=0, sat=0; done exactly 194 cycles after trigger.
REQ-035 cnt_clk=0, cnt_squ=5, cnt_pulse=0 -> freq_hz=0, duty_pm=0, period_ns=0, err_div0=1.
REQ-036 cnt_clk=500_000_000, cnt_squ=1, cnt_pulse=600_000_000 -> period_ns=0xFFFFFFFF, duty_pm=1000, freq_hz=0, sat=1.
REQ-037 Inputs changed twice while busy -> exactly one extra computation, using the final values, starting the cycle after done.
REQ-038 rst_n pulsed low mid-DIV_D -> outputs 0 immediately, no done; recomputes after release with the same results as REQ-034.
REQ-039 Inputs held constant with upd pulsed once -> exactly one done, identical results.
